c7458_bist: RTL and testbench

- Built-in self-test sequencer for the c7458 dual AND-OR gate block.
- Drives all 1024 combinations of the ten c7458 inputs.
- Samples p1y/p2y after a programmable settle time and compares them with internally computed expected values.
- Reports pass/fail, a mismatch count and the first failing vector. Sits beside c7458 in the basics test harness as its stimulus/check end.

---
 rtl/c7458_bist.sv | 125 ++++++++++++
 tb/tb_c7458_bist.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/c7458_bist.sv
// Built-in self-test sequencer for the c7458 dual AND-OR block: sweeps all 1024 input vectors and
// checks p1y/p2y. Optional macro C7458_BIST_STOP_ON_ERR_EN ends the run at the first mismatch.
module c7458_bist #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [9:0]           stim,
  input  logic                 rsp_p1y,
  input  logic                 rsp_p2y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_valid,
  output logic [9:0]           first_err_vec
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [9:0] VecLast    = 10'd1023;

  state_e               state_q, state_d;
  logic [9:0]           vec_q, vec_d;
  logic [9:0]           stim_q, stim_d;
  logic [3:0]           settle_cnt_q, settle_cnt_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 first_err_valid_q, first_err_valid_d;
  logic [9:0]           first_err_vec_q, first_err_vec_d;

  logic exp1, exp2, mismatch;

  assign exp1     = (vec_q[0] & vec_q[1] & vec_q[2]) | (vec_q[3] & vec_q[4] & vec_q[5]);
  assign exp2     = (vec_q[6] & vec_q[7]) | (vec_q[8] & vec_q[9]);
  assign mismatch = (rsp_p1y != exp1) || (rsp_p2y != exp2);

  always_comb begin
    state_d           = state_q;
    vec_d             = vec_q;
    stim_d            = stim_q;
    settle_cnt_d      = settle_cnt_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_vec_d   = first_err_vec_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          vec_d             = '0;
          stim_d            = '0;
          settle_cnt_d      = '0;
          err_count_d       = '0;
          first_err_valid_d = 1'b0;
          first_err_vec_d   = '0;
          state_d           = StSettle;
        end
      end
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d = StCheck;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          // Saturate rather than wrap so a narrow counter never reads as a pass.
          if (err_count_q != {ERR_CNT_W{1'b1}}) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_vec_d   = vec_q;
          end
        end
`ifdef C7458_BIST_STOP_ON_ERR_EN
        if (mismatch || (vec_q == VecLast)) begin
`else
        if (vec_q == VecLast) begin
`endif
          stim_d  = '0;
          state_d = StDone;
        end else begin
          vec_d        = vec_q + 10'd1;
          stim_d       = vec_q + 10'd1;
          settle_cnt_d = '0;
          state_d      = StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      vec_q             <= '0;
      stim_q            <= '0;
      settle_cnt_q      <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= '0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      stim_q            <= stim_d;
      settle_cnt_q      <= settle_cnt_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_vec_q   <= first_err_vec_d;
    end
  end

  assign stim            = stim_q;
  assign busy            = (state_q == StSettle) || (state_q == StCheck);
  assign done            = (state_q == StDone);
  assign pass            = (state_q == StDone) && (err_count_q == '0);
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_vec   = first_err_vec_q;

endmodule

// File: tb/tb_c7458_bist.sv
// Scoreboard bench for c7458_bist: two instances (settle 1 and 3) run against a c7458 model with
// selectable stuck-at faults; expected run results are queued at start and checked on done.
module tb_c7458_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   fault = 0;  // 0 ideal, 1 p2y stuck-at-0, 2 p1y stuck-at-1

  always #5 clk = ~clk;

  logic [9:0]  stim1, stim3, fvec1, fvec3;
  logic        p1y1, p2y1, p1y3, p2y3;
  logic        busy1, busy3, done1, done3, pass1, pass3, fval1, fval3;
  logic [10:0] err1, err3;

  function automatic logic [1:0] model(input logic [9:0] s, input int f);
    logic y1, y2;
    y1 = (s[0] & s[1] & s[2]) | (s[3] & s[4] & s[5]);
    y2 = (s[6] & s[7]) | (s[8] & s[9]);
    if (f == 1) y2 = 1'b0;
    if (f == 2) y1 = 1'b1;
    return {y2, y1};
  endfunction

  assign {p2y1, p1y1} = model(stim1, fault);
  assign {p2y3, p1y3} = model(stim3, fault);

  c7458_bist #(.SETTLE_CYCLES(1), .ERR_CNT_W(11)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim1), .rsp_p1y(p1y1), .rsp_p2y(p2y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_valid(fval1),
    .first_err_vec(fvec1)
  );

  c7458_bist #(.SETTLE_CYCLES(3), .ERR_CNT_W(11)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim3), .rsp_p1y(p1y3), .rsp_p2y(p2y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .first_err_valid(fval3),
    .first_err_vec(fvec3)
  );

  typedef struct {
    int         err;
    logic       valid;
    logic [9:0] fvec;
    logic       pass;
    int         lat;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   edges = 0;
  int   t0 = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Hand-derived results: p2 stuck-at-0 misses 7/16*1024 = 448 vectors, first at 0x0C0;
  // p1 stuck-at-1 misses 49/64*1024 = 784 vectors, first at 0x000.
  function automatic exp_t expect_for(input int f, input int s);
    exp_t e;
    e.err = 0; e.valid = 1'b0; e.fvec = 10'h000;
    if (f == 1) begin e.err = 448; e.valid = 1'b1; e.fvec = 10'h0C0; end
    if (f == 2) begin e.err = 784; e.valid = 1'b1; e.fvec = 10'h000; end
    e.lat = 1024 * (s + 1);
`ifdef C7458_BIST_STOP_ON_ERR_EN
    if (e.valid) begin
      e.err = 1;
      e.lat = (int'(e.fvec) + 1) * (s + 1);
    end
`endif
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic compare_done(input string tag, input exp_t e, input logic [10:0] err,
                              input logic valid, input logic [9:0] fvec, input logic pass,
                              input logic [9:0] stim, input logic busy);
    check({tag, "_err_count"}, err, e.err);
    check({tag, "_first_err_valid"}, valid, e.valid);
    check({tag, "_first_err_vec"}, fvec, e.fvec);
    check({tag, "_pass"}, pass, e.pass);
    check({tag, "_stim_idle"}, stim, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_done_latency"}, edges - t0, e.lat);
  endtask

  logic done1_prev = 1'b0;
  logic done3_prev = 1'b0;

  always @(negedge clk) begin
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb1_unexpected_done: got done, expected no pending run");
      end else begin
        compare_done("s1", q1.pop_front(), err1, fval1, fvec1, pass1, stim1, busy1);
      end
    end
    done1_prev = done1;
  end

  always @(negedge clk) begin
    if (done3 && !done3_prev) begin
      if (q3.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb3_unexpected_done: got done, expected no pending run");
      end else begin
        compare_done("s3", q3.pop_front(), err3, fval3, fvec3, pass3, stim3, busy3);
      end
    end
    done3_prev = done3;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_stim1"}, stim1, 0);
    check({tag, "_busy1"}, busy1, 0);
    check({tag, "_done1"}, done1, 0);
    check({tag, "_pass1"}, pass1, 0);
    check({tag, "_err1"}, err1, 0);
    check({tag, "_fval1"}, fval1, 0);
    check({tag, "_fvec1"}, fvec1, 0);
    check({tag, "_stim3"}, stim3, 0);
    check({tag, "_busy3"}, busy3, 0);
    check({tag, "_done3"}, done3, 0);
    check({tag, "_err3"}, err3, 0);
    check({tag, "_fval3"}, fval3, 0);
  endtask

  task automatic do_start(input int f);
    @(negedge clk);
    fault = f;
    q1.push_back(expect_for(f, 1));
    q3.push_back(expect_for(f, 3));
    start = 1'b1;
    t0 = edges + 1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy1", busy1, 1);
    check("start_busy3", busy3, 1);
    check("start_clr_err1", err1, 0);
    check("start_clr_fval1", fval1, 0);
    check("start_clr_err3", err3, 0);
  endtask

  task automatic pulse_ignored();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(done1 && done3) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!(done1 && done3)) begin
      n_tests++; n_fail++;
      $display("FAIL wait_done_timeout: got done1=%0b done3=%0b, expected both high", done1, done3);
    end
    @(negedge clk);
  endtask

  task automatic wait_stim1(input logic [9:0] v);
    int n;
    n = 0;
    while (stim1 != v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("wait_stim1_reached", stim1, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_start(0);  // ideal c7458
    wait_done();
    do_start(1);  // p2y stuck-at-0
    wait_done();
    do_start(2);  // p1y stuck-at-1
    wait_done();

`ifdef C7458_BIST_STOP_ON_ERR_EN
    do_start(0);
`else
    do_start(1);
`endif
    wait_stim1(10'd5);
    pulse_ignored();
    wait_stim1(10'd500);
    pulse_ignored();
    wait_done();
    do_start(1);  // restart from DONE
    wait_done();

    do_start(2);
    wait_stim1(10'd100);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    q1.delete();
    q3.delete();
    #6 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_busy1", busy1, 0);
    check("post_rst_done1", done1, 0);
    do_start(0);
    wait_done();

    repeat (3) @(negedge clk);
    check("sb1_drained", q1.size(), 0);
    check("sb3_drained", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
